// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
package imem_pkg;
    typedef enum logic {S_IDLE, S_ACCESS} imem_state_t;

    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h00000013;
    localparam int          WAIT_W            = 4;
endpackage

// File: rtl/imem_array.sv
// Instruction storage: synchronous write, combinational read, contents never reset.
module imem_array #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [31:0]       wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [31:0]       rd_data
);
    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: single-entry tag, wait-state counter and PC stall
// generation in front of a word-addressed instruction array.
module imem_responder
    import imem_pkg::*;
#(
    parameter int          DEPTH     = 1024,
    parameter int          WAIT      = 2,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT,
    localparam int         ADDR_W    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       pc,
    output logic              stall,
    output logic [31:0]       instr,
    output logic              instr_valid,
    output logic              addr_fault,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [31:0]       load_data
);
    imem_state_t       state, state_nxt;
    logic [WAIT_W-1:0] cnt, cnt_nxt;
    logic              tag_valid, tag_valid_nxt;
    logic [31:0]       tag_addr;
    logic [31:0]       instr_q;
    logic [31:0]       rd_data;
    logic              capture;
    logic              hit;

    imem_array #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .wr_en   (load_en),
        .wr_addr (load_addr),
        .wr_data (load_data),
        .rd_addr (pc[ADDR_W-1:0]),
        .rd_data (rd_data)
    );

    assign addr_fault = (pc >= 32'(DEPTH));
    assign hit        = (state == S_IDLE) && tag_valid && (tag_addr == pc) && !load_en;

    // Faulting addresses bypass the memory entirely so the PC keeps moving.
    always_comb begin
        instr       = instr_q;
        instr_valid = hit;
        stall       = !hit;
        if (addr_fault) begin
            instr       = NOP_INSTR;
            instr_valid = 1'b1;
            stall       = 1'b0;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        capture   = 1'b0;
        case (state)
            S_IDLE: begin
                if (!addr_fault && !hit && !load_en) begin
                    cnt_nxt   = WAIT_W'(WAIT);
                    state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: begin
                // A write restarts the wait so capture never races a write.
                if (load_en) begin
                    cnt_nxt = WAIT_W'(WAIT);
                end else if (cnt == '0) begin
                    capture   = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    cnt_nxt = cnt - WAIT_W'(1);
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        tag_valid_nxt = load_en ? 1'b0 : (capture ? 1'b1 : tag_valid);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            tag_valid <= 1'b0;
            instr_q   <= NOP_INSTR;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            tag_valid <= tag_valid_nxt;
            if (capture) begin
                instr_q <= rd_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            tag_addr <= pc;
        end
    end
endmodule
